// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: ping-pong frame-buffer controller.
// The scanner reads the front bank selected by o_rd_sel while the loader
// fills the back bank. Once the back bank holds a complete frame and the
// front bank has been shown for at least i_ram_time cycles, the banks swap
// on the next scanner frame boundary.
module fb_swap_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 54,
  parameter int FRAME_WORDS = 3200
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  input  logic              i_frame_done,
  input  logic [29:0]       i_ram_time,
  output logic              o_wr_a,
  output logic              o_wr_b,
  output logic [ADDR_W-1:0] o_addr_write,
  output logic [DATA_W-1:0] o_data_line,
  output logic              o_rd_sel,
  output logic              o_require_data,
  output logic              o_led,
  output logic              o_addr_err,
  output logic [7:0]        o_underrun_cnt
);

  // Word counter must be able to hold FRAME_WORDS itself while the
  // controller waits in S_FILLED.
  localparam int               CNT_W         = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD     = CNT_W'(FRAME_WORDS - 1);
  localparam logic [31:0]      FRAME_WORDS_U = 32'(FRAME_WORDS);

  localparam logic [1:0] S_REQUEST = 2'd0;
  localparam logic [1:0] S_FILLED  = 2'd1;
  localparam logic [1:0] S_SWAP    = 2'd2;

  logic [1:0]        state_r;
  logic [1:0]        state_next_s;
  logic [CNT_W-1:0]  count_r;
  logic [29:0]       timer_r;
  logic              rd_sel_r;
  logic              led_r;
  logic              require_r;
  logic              wr_a_r;
  logic              wr_b_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic              addr_err_r;
  logic [7:0]        underrun_r;

  logic              wr_ready_s;
  logic              accept_s;
  logic              in_range_s;
  logic              last_accept_s;
  logic              timer_zero_s;
  logic              swap_s;
  logic              underrun_s;

  // Decode the events that drive both the FSM and the datapath registers.
  always_comb begin
    accept_s      = 1'b0;
    in_range_s    = 1'b0;
    last_accept_s = 1'b0;
    timer_zero_s  = 1'b0;
    swap_s        = 1'b0;
    underrun_s    = 1'b0;
    accept_s      = i_wr_valid & wr_ready_s;
    in_range_s    = (32'(i_wr_addr) < FRAME_WORDS_U);
    last_accept_s = accept_s & (count_r == LAST_WORD);
    timer_zero_s  = (timer_r == 30'd0);
    swap_s        = (state_r == S_FILLED) & timer_zero_s & i_frame_done;
    // A frame boundary outside S_FILLED after the hold has expired means the
    // scanner had to repeat the front frame.
    underrun_s    = i_frame_done & timer_zero_s & (state_r != S_FILLED);
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= S_REQUEST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_REQUEST: begin
        if (last_accept_s) begin
          state_next_s = S_FILLED;
        end else begin
          state_next_s = S_REQUEST;
        end
      end
      S_FILLED: begin
        if (swap_s) begin
          state_next_s = S_SWAP;
        end else begin
          state_next_s = S_FILLED;
        end
      end
      S_SWAP:  state_next_s = S_REQUEST;
      default: state_next_s = S_REQUEST;
    endcase
  end

  // FSM combinational output: the loader handshake is open only while filling.
  always_comb begin
    wr_ready_s = 1'b0;
    if (i_rst) begin
      wr_ready_s = 1'b0;
    end else begin
      wr_ready_s = (state_r == S_REQUEST);
    end
  end

  // Data request goes high one cycle after entering S_REQUEST and drops
  // together with the state leaving it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      require_r <= 1'b0;
    end else begin
      require_r <= (state_r == S_REQUEST) & (state_next_s == S_REQUEST);
    end
  end

  // Write path: register address/data and strobe only the back bank.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_a_r     <= 1'b0;
      wr_b_r     <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      data_r     <= {DATA_W{1'b0}};
      addr_err_r <= 1'b0;
    end else if (accept_s) begin
      // Back bank is the one not being read: A when rd_sel = 1.
      wr_a_r     <= in_range_s & rd_sel_r;
      wr_b_r     <= in_range_s & ~rd_sel_r;
      addr_r     <= i_wr_addr;
      data_r     <= i_wr_data;
      addr_err_r <= addr_err_r | ~in_range_s;
    end else begin
      wr_a_r     <= 1'b0;
      wr_b_r     <= 1'b0;
      addr_r     <= addr_r;
      data_r     <= data_r;
      addr_err_r <= addr_err_r;
    end
  end

  // Frame word count: every accept counts, cleared when the bank swaps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (swap_s) begin
      count_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  // Minimum display time: loaded at the swap, counts down to zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timer_r <= 30'd0;
    end else if (swap_s) begin
      timer_r <= i_ram_time;
    end else if (!timer_zero_s) begin
      timer_r <= timer_r - 30'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Front-bank select and status LED flip together on each swap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_sel_r <= 1'b0;
      led_r    <= 1'b0;
    end else if (swap_s) begin
      rd_sel_r <= ~rd_sel_r;
      led_r    <= ~led_r;
    end else begin
      rd_sel_r <= rd_sel_r;
      led_r    <= led_r;
    end
  end

  // Saturating count of frame boundaries that found no new frame ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      underrun_r <= 8'd0;
    end else if (underrun_s && (underrun_r != 8'hFF)) begin
      underrun_r <= underrun_r + 8'd1;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign o_wr_ready     = wr_ready_s;
  assign o_wr_a         = wr_a_r;
  assign o_wr_b         = wr_b_r;
  assign o_addr_write   = addr_r;
  assign o_data_line    = data_r;
  assign o_rd_sel       = rd_sel_r;
  assign o_require_data = require_r;
  assign o_led          = led_r;
  assign o_addr_err     = addr_err_r;
  assign o_underrun_cnt = underrun_r;

endmodule

// File: doc/fb_swap_ctrl.md
Name: fb_swap_ctrl

Overview:
Ping-pong frame-buffer controller that places two dual-port image RAM banks (A, B) between the frame loader and the HUB75 panel scanner. The scanner reads the front bank while the loader fills the back bank. On a frame boundary, once the back bank is complete and the minimum display time has elapsed, the block swaps the banks. It owns the bank write enables, the front-bank read select, the loader data request and the status LED.

Parameters:
ADDR_W, 12, RAM word address width
DATA_W, 54, RAM word width (6 pixels x 9 bit RGB)
FRAME_WORDS, 3200, words per full frame (160 columns x 20 rows)

Ports:
i_clk  in  1  single clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_wr_valid  in  1  loader presents a word
i_wr_addr  in  ADDR_W  loader word address
i_wr_data  in  DATA_W  loader word data
o_wr_ready  out  1  word accepted when valid & ready
i_frame_done  in  1  one-cycle pulse from scanner at end of last row of last PWM step
i_ram_time  in  30  minimum cycles a bank stays front after a swap
o_wr_a  out  1  write strobe, bank A
o_wr_b  out  1  write strobe, bank B
o_addr_write  out  ADDR_W  registered write address, shared by both banks
o_data_line  out  DATA_W  registered write data, shared by both banks
o_rd_sel  out  1  front bank: 0 = A, 1 = B
o_require_data  out  1  loader may send a frame
o_led  out  1  toggles on every swap
o_addr_err  out  1  sticky: an out-of-range address was accepted
o_underrun_cnt  out  8  saturating count of missed frame boundaries

Behaviour:
- Reset values (while i_rst = 1 and on the first cycle after): state S_REQUEST, o_rd_sel 0, o_led 0, o_wr_a/o_wr_b 0, o_addr_write 0, o_data_line 0, o_require_data 0, o_addr_err 0, o_underrun_cnt 0, word count 0, hold timer 0. o_wr_ready is forced to 0 while i_rst = 1.
- States:
  - S_REQUEST: fill the back bank.
  - S_FILLED: wait for swap.
  - S_SWAP: one-cycle guard.
- o_require_data is registered and equals 1 on the cycle after entry into S_REQUEST, until state leaves S_REQUEST.
- o_wr_ready is combinational: (state == S_REQUEST) & !i_rst.
- Write path:
  - On accept, the next edge drives o_addr_write = i_wr_addr and o_data_line = i_wr_data. Exactly one of o_wr_a/o_wr_b pulses for one cycle, selecting the back bank (~o_rd_sel). Latency is 1 cycle.
  - The front bank is never written.
  - An accept with i_wr_addr >= FRAME_WORDS produces no strobe, sets o_addr_err, and is still counted.
- Word count: increments per accept. The accept taking the count to FRAME_WORDS moves state to S_FILLED, and the count holds. No further accepts in S_FILLED or S_SWAP.
- Hold timer: decrements by 1 every cycle while nonzero, saturating at 0. It is loaded with i_ram_time on the swap edge.
- Swap condition: state == S_FILLED, timer == 0, and i_frame_done = 1. On that edge:
  - o_rd_sel and o_led toggle;
  - timer is loaded;
  - count clears;
  - state goes to S_SWAP.
- S_SWAP always moves to S_REQUEST on the next edge, so o_require_data reasserts 2 cycles after the swap edge.
- i_frame_done in S_FILLED with timer != 0: ignored, with no count increment.
- i_frame_done in S_REQUEST or S_SWAP with timer == 0: o_underrun_cnt increments, saturating at 255. The front bank is kept, with no swap.
- i_frame_done in S_REQUEST with timer != 0: ignored.
- i_ram_time = 0: the swap happens at the first frame_done after fill.
- i_ram_time changes mid-hold: takes effect at the next swap only.
- Simultaneous last accept and i_frame_done: the state is still S_REQUEST, so an underrun is counted if timer == 0. The swap can occur no earlier than the next frame_done.
- The final write strobe always lands before any swap, because S_FILLED lasts at least 1 cycle.
- Reset mid-operation: all state returns to reset values on the next edge and any in-flight strobe is dropped. Back bank contents are undefined; front bank contents are untouched.

Test Plan:
1. Reset, then FRAME_WORDS = 4, i_ram_time = 0. Stream 4 words to addresses 0..3 -> o_wr_b pulses 4x with 1-cycle latency and o_wr_a stays 0. o_wr_ready drops after the 4th accept. A frame_done pulse then flips o_rd_sel to 1 and o_led to 1, and o_require_data returns 2 cycles later.
2. After test 1, fill again -> the strobes go to o_wr_a only, and the next swap returns o_rd_sel to 0.
3. i_ram_time = 20. Fill, swap, then refill within 5 cycles and pulse frame_done at cycle 10 -> no swap. A pulse at cycle 25 after the swap -> swap.
4. i_ram_time = 0, loader idle after a swap, 300 frame_done pulses -> o_underrun_cnt = 255 (saturated) and o_rd_sel is unchanged.
5. Accept address 4 with FRAME_WORDS = 4 -> no strobe, o_addr_err = 1 and sticky, word count still advances.
6. Assert i_rst for 1 cycle after 2 of 4 words -> all outputs return to reset values and o_wr_ready = 0 during reset. A full 4-word refill then goes to bank B.
